// File: rtl/uart_rx_core_if.sv
// UART receiver bus: baud tick and serial line in, received byte and status out.
// No latency of its own; it only groups wires.
// No backpressure: every received byte is presented for exactly one clock.
interface uart_rx_core_if #(
  parameter int N = 8
);
  logic         i_tick;
  logic         i_rx;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic [3:0]   o_state_leds;
  logic         o_started;

  // Stimulus side: drives the tick and the line, observes the results.
  modport master (
    output i_tick,
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_state_leds,
    input  o_started
  );

  // Receiver side.
  modport slave (
    input  i_tick,
    input  i_rx,
    output o_data,
    output o_valid,
    output o_state_leds,
    output o_started
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with COUNT_TICKS-times oversampling driven by an external baud tick.
// Latency: 2 clk synchronizer; o_valid is registered and rises at the mid-stop-bit sample.
// No backpressure: o_valid is a one-clock pulse, and o_data holds until the next good frame.
module uart_rx_core #(
  parameter int N           = 8,
  parameter int COUNT_TICKS = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_core_if.slave bus
);

  localparam int TW = (COUNT_TICKS > 2) ? $clog2(COUNT_TICKS) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(COUNT_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(COUNT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q,    state_d;
  logic [1:0]    rx_sync_q,  rx_sync_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [N-1:0]  shift_q,    shift_d;
  logic [N-1:0]  data_q,     data_d;
  logic          valid_q,    valid_d;
  // Cleared by a framing error so a held-low line (break) cannot start a
  // new frame until the line has been seen high again.
  logic          armed_q,    armed_d;

  logic rx_s;
  assign rx_s = rx_sync_q[1];

  // State register, counters, synchronizer and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rx_sync_q  <= 2'b11;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rx_sync_q  <= rx_sync_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state logic: only the IDLE->START move ignores the baud tick.
  always_comb begin
    state_d    = state_q;
    rx_sync_d  = {rx_sync_q[0], bus.i_rx};
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    armed_d    = armed_q | rx_s;

    case (state_q)
      S_IDLE: begin
        if (!rx_s && armed_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end

      S_START: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            if (!rx_s) begin
              // Start bit still low at its centre: all later samples are
              // a full bit period apart and land mid-bit.
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            // LSB arrives first, so shifting in at the top leaves the
            // byte LSB-aligned after N samples.
            shift_d    = {rx_s, shift_q[N-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              armed_d = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_state_leds = 4'b0001 << state_q;
  assign bus.o_started    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives 8N1 frames and checks received bytes against a byte-level model.
// Latency: the mid-stop-bit timing of o_valid is checked against a window.
// No backpressure: every o_valid pulse is captured by a monitor into a queue.
module tb_uart_rx_core;
  localparam int N        = 8;
  localparam int CT       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = CT * TICK_DIV;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  uart_rx_core_if #(.N(N)) bus ();

  uart_rx_core #(.N(N), .COUNT_TICKS(CT)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Monitor state
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  logic       prev_valid = 1'b0;
  logic       dbl_valid  = 1'b0;
  logic       seen_started = 1'b0;

  // Free-running baud tick, one clock high every TICK_DIV clocks.
  initial begin
    int tdiv;
    tdiv = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      bus.i_tick = (tdiv == 0);
    end
  end

  // Capture every valid pulse and flag back-to-back valids.
  always @(negedge i_clk) begin
    cyc = cyc + 1;
    if (!i_rst) begin
      if (bus.o_valid) begin
        got_q.push_back(bus.o_data);
        got_cyc.push_back(cyc);
        if (prev_valid) dbl_valid = 1'b1;
      end
      if (bus.o_started) seen_started = 1'b1;
    end
    prev_valid = bus.o_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.i_rx = 1'b0;
    clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      clks(BIT_CLK);
    end
    bus.i_rx = stop_bit;
    clks(BIT_CLK);
    bus.i_rx = 1'b1;
  endtask

  task automatic test_reset;
    // Still in the power-on reset here
    total++;
    if (bus.o_state_leds !== 4'b0001 || bus.o_started !== 1'b0 ||
        bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_initial: leds=%b started=%b valid=%b data=%h, want 0001 0 0 00",
               bus.o_state_leds, bus.o_started, bus.o_valid, bus.o_data);
    end
    i_rst = 1'b0;
    clks(4);
    send_frame(8'h5A, 1'b1);
    clks(BIT_CLK);
    total++;
    if (bus.o_data !== 8'h5A) begin
      bad++;
      $display("FAIL reset_prep_data: got %h want 5a", bus.o_data);
    end
    // Start a frame, then reset in the middle of it
    bus.i_rx = 1'b0;
    clks(3 * BIT_CLK);
    i_rst = 1'b1;
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 ||
        bus.o_state_leds !== 4'b0001 || bus.o_started !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: valid=%b data=%h leds=%b started=%b, want 0 00 0001 0",
               bus.o_valid, bus.o_data, bus.o_state_leds, bus.o_started);
    end
    bus.i_rx = 1'b1;
    clks(3);
    i_rst = 1'b0;
    clks(2 * BIT_CLK);
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_single;
    logic [7:0] b;
    int t0;
    b = 8'h08;
    t0 = cyc;
    bus.i_rx = 1'b0;
    clks(20);
    total++;
    if (bus.o_state_leds !== 4'b0010 || bus.o_started !== 1'b1) begin
      bad++;
      $display("FAIL single_start_state: leds=%b started=%b want 0010 1",
               bus.o_state_leds, bus.o_started);
    end
    clks(BIT_CLK - 20);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      if (i == 3) begin
        clks(BIT_CLK / 2);
        total++;
        if (bus.o_state_leds !== 4'b0100 || bus.o_started !== 1'b1) begin
          bad++;
          $display("FAIL single_data_state: leds=%b started=%b want 0100 1",
                   bus.o_state_leds, bus.o_started);
        end
        clks(BIT_CLK - BIT_CLK / 2);
      end else begin
        clks(BIT_CLK);
      end
    end
    bus.i_rx = 1'b1;
    clks(3 * BIT_CLK);
    total++;
    if (got_q.size() !== 1) begin
      bad++;
      $display("FAIL single_count: got %0d pulses want 1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== 8'h08) begin
        bad++;
        $display("FAIL single_byte: got %h want 08", got_q[0]);
      end
      // Mid-stop-bit is 9.5 bit times after the falling start edge
      total++;
      if (got_cyc[0] - t0 < 9 * BIT_CLK + BIT_CLK / 2 - 12 ||
          got_cyc[0] - t0 > 9 * BIT_CLK + BIT_CLK / 2 + 22) begin
        bad++;
        $display("FAIL single_timing: valid %0d clk after start edge, want about %0d",
                 got_cyc[0] - t0, 9 * BIT_CLK + BIT_CLK / 2);
      end
    end
    total++;
    if (bus.o_data !== 8'h08 || bus.o_state_leds !== 4'b0001) begin
      bad++;
      $display("FAIL single_hold: data=%h leds=%b want 08 0001", bus.o_data, bus.o_state_leds);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    exp_q = '{8'h07, 8'h0B, 8'h07, 8'h00, 8'h01, 8'h3C};
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
    clks(2 * BIT_CLK);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_glitch;
    seen_started = 1'b0;
    bus.i_rx = 1'b0;
    clks(3 * TICK_DIV);
    bus.i_rx = 1'b1;
    clks(2 * BIT_CLK);
    total++;
    if (seen_started !== 1'b1 || got_q.size() !== 0 || bus.o_state_leds !== 4'b0001) begin
      bad++;
      $display("FAIL glitch: started_seen=%b pulses=%0d leds=%b want 1 0 0001",
               seen_started, got_q.size(), bus.o_state_leds);
    end
    send_frame(8'h52, 1'b1);
    clks(BIT_CLK);
    total++;
    if (got_q.size() !== 1 || bus.o_data !== 8'h52) begin
      bad++;
      $display("FAIL glitch_after: pulses=%0d data=%h want 1 52", got_q.size(), bus.o_data);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_framing;
    send_frame(8'hA5, 1'b0);
    // Keep the line low (break) for two more bit times
    bus.i_rx = 1'b0;
    clks(BIT_CLK);
    total++;
    if (bus.o_started !== 1'b0) begin
      bad++;
      $display("FAIL framing_break_retrigger: started=%b want 0", bus.o_started);
    end
    clks(BIT_CLK);
    bus.i_rx = 1'b1;
    clks(2 * BIT_CLK);
    total++;
    if (got_q.size() !== 0 || bus.o_data !== 8'h52) begin
      bad++;
      $display("FAIL framing_discard: pulses=%0d data=%h want 0 52", got_q.size(), bus.o_data);
    end
    send_frame(8'h0D, 1'b1);
    clks(BIT_CLK);
    total++;
    if (got_q.size() !== 1 || bus.o_data !== 8'h0D) begin
      bad++;
      $display("FAIL framing_next: pulses=%0d data=%h want 1 0d", got_q.size(), bus.o_data);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset_midframe;
    bus.i_rx = 1'b0;
    clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      bus.i_rx = 1'b1;
      clks(BIT_CLK);
    end
    clks(BIT_CLK / 2);
    i_rst = 1'b1;
    #1;
    total++;
    if (bus.o_started !== 1'b0 || bus.o_data !== 8'h00) begin
      bad++;
      $display("FAIL midframe_reset: started=%b data=%h want 0 00", bus.o_started, bus.o_data);
    end
    clks(3);
    i_rst = 1'b0;
    clks(6 * BIT_CLK);
    total++;
    if (got_q.size() !== 0 || bus.o_data !== 8'h00) begin
      bad++;
      $display("FAIL midframe_no_valid: pulses=%0d data=%h want 0 00", got_q.size(), bus.o_data);
    end
    send_frame(8'h11, 1'b1);
    clks(BIT_CLK);
    total++;
    if (got_q.size() !== 1 || bus.o_data !== 8'h11) begin
      bad++;
      $display("FAIL midframe_next: pulses=%0d data=%h want 1 11", got_q.size(), bus.o_data);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       good;
    logic [7:0] last_good;
    int         gap;
    last_good = 8'h11;
    for (int k = 0; k < 16; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
      end
      // After a framing error the line must idle high before the next start
      gap = $urandom_range(0, 2 * BIT_CLK);
      if (!good) gap = gap + BIT_CLK;
      if (gap > 0) clks(gap);
    end
    clks(2 * BIT_CLK);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (bus.o_data !== last_good) begin
      bad++;
      $display("FAIL random_hold: data=%h want %h", bus.o_data, last_good);
    end
    total++;
    if (dbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_width: consecutive-valid flag=%b want 0", dbl_valid);
    end
  endtask

  initial begin
    bus.i_rx = 1'b1;
    i_rst = 1'b1;
    clks(5);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
